// File: rtl/j17_pkg.sv
// Shared definitions for the J17 data-memory block: stack opcode encoding and default widths.
package j17_pkg;

  localparam int J17_DATA_W = 32;
  localparam int J17_ADDR_W = 10;

  typedef enum logic [1:0] {
    STACK_NONE = 2'b00,
    STACK_PUSH = 2'b01,
    STACK_POP  = 2'b10,
    STACK_RSVD = 2'b11
  } stack_op_e;

endpackage

// File: rtl/j17_ram_2p.sv
// DEPTH x DATA_W array with two registered write-first read ports and two write ports;
// port B (stack) wins when both write the same address on one edge.
module j17_ram_2p
  import j17_pkg::*;
#(
  parameter int DATA_W    = J17_DATA_W,
  parameter int ADDR_W    = J17_ADDR_W,
  parameter     INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic              we_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              we_b,
  input  logic              re_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_a_d, rdata_a_q;
  logic [DATA_W-1:0] rdata_b_d, rdata_b_q;

  // Read data reflects whatever this edge stores, with port B taking precedence.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    rdata_a_d = mem[addr_a];
    if (we_a)                      rdata_a_d = wdata_a;
    if (we_b && addr_b == addr_a)  rdata_a_d = wdata_b;

    rdata_b_d = rdata_b_q;
    if (re_b) begin
      rdata_b_d = mem[addr_b];
      if (we_a && addr_a == addr_b) rdata_b_d = wdata_a;
      if (we_b)                     rdata_b_d = wdata_b;
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM; contents survive a reset.
  always_ff @(posedge clock) begin
    if (we_a) mem[addr_a] <= wdata_a;
    if (we_b) mem[addr_b] <= wdata_b;  // later assignment gives port B the collision
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: rtl/j17_data_mem.sv
// J17 data-memory responder: data port plus a downward-growing hardware stack kept in the
// top STACK_DEPTH words of the same array.
module j17_data_mem
  import j17_pkg::*;
#(
  parameter int DATA_W      = J17_DATA_W,
  parameter int ADDR_W      = J17_ADDR_W,
  parameter int STACK_DEPTH = 64,
  parameter     INIT_FILE   = ""
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] memaddr,
  input  logic              writemem,
  input  logic [DATA_W-1:0] writememdata,
  output logic [DATA_W-1:0] memresult,
  input  logic [1:0]        stackSelect,
  input  logic [DATA_W-1:0] stack_wdata,
  output logic [DATA_W-1:0] stack_rdata,
  output logic [ADDR_W:0]   sp,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_err
);

  localparam int              SP_W     = ADDR_W + 1;
  localparam logic [ADDR_W:0] SP_EMPTY = SP_W'(1) << ADDR_W;
  localparam logic [ADDR_W:0] SP_FULL  = SP_EMPTY - SP_W'(STACK_DEPTH);

  stack_op_e         op;
  logic [ADDR_W:0]   sp_d, sp_q;
  logic              err_d, err_q;
  logic              pop_zero_d, pop_zero_q;
  logic              push_ok, pop_ok;
  logic [ADDR_W-1:0] push_addr, stack_addr;
  logic [DATA_W-1:0] ram_rdata_b;

  assign op          = stack_op_e'(stackSelect);
  assign stack_empty = (sp_q == SP_EMPTY);
  assign stack_full  = (sp_q == SP_FULL);
  assign push_addr   = sp_q[ADDR_W-1:0] - 1'b1;
  assign stack_addr  = pop_ok ? sp_q[ADDR_W-1:0] : push_addr;

  always_comb begin
    sp_d       = sp_q;
    err_d      = err_q;
    pop_zero_d = pop_zero_q;
    push_ok    = 1'b0;
    pop_ok     = 1'b0;
    case (op)
      STACK_PUSH: begin
        if (stack_full) begin
          err_d = 1'b1;
        end else begin
          push_ok = 1'b1;
          sp_d    = sp_q - 1'b1;
        end
      end
      STACK_POP: begin
        if (stack_empty) begin
          err_d      = 1'b1;
          pop_zero_d = 1'b1;
        end else begin
          pop_ok     = 1'b1;
          pop_zero_d = 1'b0;
          sp_d       = sp_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp_q       <= SP_EMPTY;
      err_q      <= 1'b0;
      pop_zero_q <= 1'b0;
    end else begin
      sp_q       <= sp_d;
      err_q      <= err_d;
      pop_zero_q <= pop_zero_d;
    end
  end

  // Writes are gated by reset so a write coinciding with a reset edge is dropped.
  j17_ram_2p #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .addr_a  (memaddr),
    .we_a    (writemem & ~reset),
    .wdata_a (writememdata),
    .rdata_a (memresult),
    .addr_b  (stack_addr),
    .we_b    (push_ok & ~reset),
    .re_b    (pop_ok),
    .wdata_b (stack_wdata),
    .rdata_b (ram_rdata_b)
  );

  assign stack_rdata = pop_zero_q ? '0 : ram_rdata_b;
  assign sp          = sp_q;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_j17_data_mem.sv
// Directed bench for j17_data_mem: data port, bypass, stack push/pop, full/empty errors, reset.
module tb_j17_data_mem;

  logic        clock;
  logic        reset;
  logic [9:0]  memaddr;
  logic        writemem;
  logic [31:0] writememdata;
  logic [31:0] memresult;
  logic [1:0]  stackSelect;
  logic [31:0] stack_wdata;
  logic [31:0] stack_rdata;
  logic [10:0] sp;
  logic        stack_empty;
  logic        stack_full;
  logic        stack_err;

  int checks = 0;
  int errors = 0;

  j17_data_mem dut (
    .clock        (clock),
    .reset        (reset),
    .memaddr      (memaddr),
    .writemem     (writemem),
    .writememdata (writememdata),
    .memresult    (memresult),
    .stackSelect  (stackSelect),
    .stack_wdata  (stack_wdata),
    .stack_rdata  (stack_rdata),
    .sp           (sp),
    .stack_empty  (stack_empty),
    .stack_full   (stack_full),
    .stack_err    (stack_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    writemem    = 1'b0;
    stackSelect = 2'b00;
  endtask

  task automatic push(input logic [31:0] v);
    stackSelect = 2'b01;
    stack_wdata = v;
    tick();
    stackSelect = 2'b00;
  endtask

  task automatic pop();
    stackSelect = 2'b10;
    tick();
    stackSelect = 2'b00;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    memaddr      = a;
    writemem     = 1'b1;
    writememdata = d;
    tick();
    writemem     = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    memaddr      = '0;
    writemem     = 1'b0;
    writememdata = '0;
    stackSelect  = 2'b00;
    stack_wdata  = '0;
    tick();
    tick();
    check("rst_memresult", memresult, 32'h0);
    check("rst_stack_rdata", stack_rdata, 32'h0);
    check("rst_sp", 32'(sp), 32'd1024);
    check("rst_empty", 32'(stack_empty), 32'd1);
    check("rst_full", 32'(stack_full), 32'd0);
    check("rst_err", 32'(stack_err), 32'd0);
    reset = 1'b0;
    tick();

    // 1: plain write then registered read
    wr(10'd5, 32'h1234_5678);
    memaddr = 10'd5;
    tick();
    check("t1_read5", memresult, 32'h1234_5678);

    // 2: same-edge write/read bypass
    memaddr      = 10'd7;
    writemem     = 1'b1;
    writememdata = 32'hA5A5_A5A5;
    tick();
    check("t2_bypass7", memresult, 32'hA5A5_A5A5);
    writemem = 1'b0;
    memaddr  = 10'd5;
    tick();
    check("t2_addr5_intact", memresult, 32'h1234_5678);

    // 3: push three, pop three
    push(32'h1);
    push(32'h2);
    push(32'h3);
    check("t3_sp_after_push", 32'(sp), 32'd1021);
    check("t3_not_empty", 32'(stack_empty), 32'd0);
    pop();
    check("t3_pop1", stack_rdata, 32'h3);
    check("t3_sp_pop1", 32'(sp), 32'd1022);
    pop();
    check("t3_pop2", stack_rdata, 32'h2);
    pop();
    check("t3_pop3", stack_rdata, 32'h1);
    check("t3_sp_final", 32'(sp), 32'd1024);
    check("t3_empty", 32'(stack_empty), 32'd1);
    tick();
    check("t3_rdata_hold", stack_rdata, 32'h1);
    check("t3_no_err", 32'(stack_err), 32'd0);

    // 4: fill the stack, overflow once, drain
    wr(10'd959, 32'h0000_CAFE);
    for (int i = 0; i < 64; i++) push(32'h100 + 32'(i));
    check("t4_full", 32'(stack_full), 32'd1);
    check("t4_sp_full", 32'(sp), 32'd960);
    check("t4_err_before", 32'(stack_err), 32'd0);
    push(32'hFFFF_FFFF);
    check("t4_sp_overflow", 32'(sp), 32'd960);
    check("t4_err_overflow", 32'(stack_err), 32'd1);
    memaddr = 10'd959;
    tick();
    check("t4_below_stack_intact", memresult, 32'h0000_CAFE);
    pop();
    check("t4_pop_top", stack_rdata, 32'h13F);
    check("t4_sp_after_pop", 32'(sp), 32'd961);
    check("t4_not_full", 32'(stack_full), 32'd0);
    for (int i = 62; i >= 0; i--) begin
      pop();
      check($sformatf("t4_drain%0d", i), stack_rdata, 32'h100 + 32'(i));
    end
    check("t4_sp_drained", 32'(sp), 32'd1024);

    // 5: underflow after reset; sticky error
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_err_cleared", 32'(stack_err), 32'd0);
    push(32'h55);
    pop();
    check("t5_pop55", stack_rdata, 32'h55);
    pop();
    check("t5_underflow_rdata", stack_rdata, 32'h0);
    check("t5_underflow_sp", 32'(sp), 32'd1024);
    check("t5_underflow_err", 32'(stack_err), 32'd1);
    tick();
    check("t5_zero_hold", stack_rdata, 32'h0);
    push(32'h66);
    pop();
    check("t5_pop66", stack_rdata, 32'h66);
    check("t5_err_sticky", 32'(stack_err), 32'd1);

    // 6: data write and push collide on 1023; push wins
    memaddr      = 10'd1023;
    writemem     = 1'b1;
    writememdata = 32'h0000_DEAD;
    stackSelect  = 2'b01;
    stack_wdata  = 32'h0000_BEEF;
    tick();
    idle();
    check("t6_collide_bypass", memresult, 32'h0000_BEEF);
    check("t6_sp", 32'(sp), 32'd1023);
    tick();
    check("t6_mem1023", memresult, 32'h0000_BEEF);

    // reset with an in-flight data write: write is dropped, outputs cleared
    writemem     = 1'b1;
    writememdata = 32'h0000_1111;
    reset        = 1'b1;
    tick();
    check("t6_rst_sp", 32'(sp), 32'd1024);
    check("t6_rst_memresult", memresult, 32'h0);
    check("t6_rst_err", 32'(stack_err), 32'd0);
    check("t6_rst_rdata", stack_rdata, 32'h0);
    writemem = 1'b0;
    reset    = 1'b0;
    tick();
    check("t6_mem_survives", memresult, 32'h0000_BEEF);

    // pop with a same-edge data write to mem[sp] returns the new word
    push(32'h77);
    memaddr      = 10'd1023;
    writemem     = 1'b1;
    writememdata = 32'h88;
    stackSelect  = 2'b10;
    tick();
    idle();
    check("t7_pop_bypass", stack_rdata, 32'h88);
    check("t7_sp", 32'(sp), 32'd1024);

    // reserved opcode does nothing
    stackSelect = 2'b11;
    tick();
    idle();
    check("t8_rsvd_sp", 32'(sp), 32'd1024);
    check("t8_rsvd_rdata", stack_rdata, 32'h88);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
